// File: rtl/biquad_filter.sv
// biquad_filter: Direct Form I biquad, one shared multiplier, one sample per 7-cycle slot.
// Define SATURATE_EN to clamp the output reduction to the signed sample range instead of wrapping.
module biquad_filter #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int FRAC_BITS    = 16,
  parameter int ACC_WIDTH    = 52
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           coef_load,
  input  logic signed [SAMPLE_WIDTH-1:0] b0,
  input  logic signed [SAMPLE_WIDTH-1:0] b1,
  input  logic signed [SAMPLE_WIDTH-1:0] b2,
  input  logic signed [SAMPLE_WIDTH-1:0] a0,
  input  logic signed [SAMPLE_WIDTH-1:0] a1,
  input  logic signed [SAMPLE_WIDTH-1:0] a2,
  input  logic                           clear_state,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                           sample_valid,
  output logic                           sample_ready,
  output logic signed [SAMPLE_WIDTH-1:0] sample_out,
  output logic                           out_valid
);
  localparam int PW = 2 * SAMPLE_WIDTH;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] MAC0 = 3'd1;
  localparam logic [2:0] MAC3 = 3'd4;
  localparam logic [2:0] MAC4 = 3'd5;
  localparam logic [2:0] OUT  = 3'd6;

  typedef logic signed [SAMPLE_WIDTH-1:0] smp_t;
  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic [2:0] state_q, state_d;
  logic       alive_q, alive_d;
  logic       clr_pend_q, clr_pend_d;
  logic       out_valid_q, out_valid_d;
  smp_t       sample_out_q, sample_out_d;
  acc_t       acc_q, acc_d;
  // Coefficient slots are b0, b1, b2, a1, a2; data slots x0, x1, x2, y1, y2 share the index.
  smp_t       shd_q [5];
  smp_t       shd_d [5];
  smp_t       cof_q [5];
  smp_t       cof_d [5];
  smp_t       dat_q [5];
  smp_t       dat_d [5];

  logic [2:0]           k;
  logic signed [PW-1:0] prod;
  acc_t                 prod_ext;
  logic                 sub, accept, hist_clr, unused_a0;
  smp_t                 y;

  assign unused_a0    = ^a0;
  assign sample_ready = alive_q && state_q == IDLE;
  assign accept       = sample_valid && sample_ready;
  assign k            = (state_q >= MAC0 && state_q <= MAC4) ? state_q - MAC0 : 3'd0;
  assign prod         = PW'(cof_q[k]) * PW'(dat_q[k]);
  assign prod_ext     = ACC_WIDTH'(prod);
  assign sub          = state_q == MAC3 || state_q == MAC4;
  // A clear raised while busy waits for the OUT edge so the current output is still emitted.
  assign hist_clr     = (state_q == IDLE && clear_state) || (state_q == OUT && (clr_pend_q || clear_state));
  assign sample_out   = sample_out_q;
  assign out_valid    = out_valid_q;

`ifdef SATURATE_EN
  acc_t shifted;
  logic ovf;
  assign shifted = acc_q >>> FRAC_BITS;
  assign ovf     = !(&shifted[ACC_WIDTH-1:SAMPLE_WIDTH-1]) && (|shifted[ACC_WIDTH-1:SAMPLE_WIDTH-1]);
  assign y       = !ovf ? shifted[SAMPLE_WIDTH-1:0] :
                   shifted[ACC_WIDTH-1] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}} : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
`else
  assign y = acc_q[FRAC_BITS +: SAMPLE_WIDTH];
`endif

  always_comb begin
    state_d      = state_q;
    alive_d      = 1'b1;
    clr_pend_d   = clr_pend_q;
    out_valid_d  = 1'b0;
    sample_out_d = sample_out_q;
    acc_d        = acc_q;
    shd_d        = shd_q;
    cof_d        = cof_q;
    dat_d        = dat_q;
    if (coef_load) shd_d = '{b0, b1, b2, a1, a2};
    if (state_q == IDLE) begin
      if (accept) begin
        state_d  = MAC0;
        acc_d    = '0;
        cof_d    = shd_q;
        dat_d[0] = sample_in;
      end
    end else if (state_q == OUT) begin
      state_d      = IDLE;
      clr_pend_d   = 1'b0;
      out_valid_d  = 1'b1;
      sample_out_d = y;
      dat_d[2]     = dat_q[1];
      dat_d[1]     = dat_q[0];
      dat_d[4]     = dat_q[3];
      dat_d[3]     = y;
    end else begin
      acc_d      = sub ? acc_q - prod_ext : acc_q + prod_ext;
      state_d    = state_q + 3'd1;
      clr_pend_d = clr_pend_q | clear_state;
    end
    if (hist_clr) for (int i = 1; i < 5; i++) dat_d[i] = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      alive_q      <= 1'b0;
      clr_pend_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      sample_out_q <= '0;
      acc_q        <= '0;
      for (int i = 0; i < 5; i++) begin
        shd_q[i] <= '0;
        cof_q[i] <= '0;
        dat_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      alive_q      <= alive_d;
      clr_pend_q   <= clr_pend_d;
      out_valid_q  <= out_valid_d;
      sample_out_q <= sample_out_d;
      acc_q        <= acc_d;
      shd_q        <= shd_d;
      cof_q        <= cof_d;
      dat_q        <= dat_d;
    end
  end
endmodule

// File: tb/tb_biquad_filter.sv
// tb_biquad_filter: directed and randomized checks of biquad_filter against a behavioural model.
module tb_biquad_filter;
  localparam int W = 24;

  logic clk = 0, reset = 0, coef_load = 0, clear_state = 0, sample_valid = 0;
  logic signed [W-1:0] b0 = 0, b1 = 0, b2 = 0, a0 = 24'sd65536, a1 = 0, a2 = 0, sample_in = 0;
  logic sample_ready, out_valid;
  logic signed [W-1:0] sample_out;

  int checks = 0, errors = 0;
  longint sh[5], act[5], x1, x2, y1, y2, exp_y, cyc, due = -1, last = 0;
  bit alive, busy, done;
  longint lit[32];
  int lit_n = 0, lit_i = 0;

  always #5 clk = ~clk;

  biquad_filter dut (
    .clk(clk), .reset(reset), .coef_load(coef_load),
    .b0(b0), .b1(b1), .b2(b2), .a0(a0), .a1(a1), .a2(a2),
    .clear_state(clear_state), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_out(sample_out), .out_valid(out_valid)
  );

  function automatic longint reduce(longint s);
`ifdef SATURATE_EN
    return s > 8388607 ? 8388607 : s < -8388608 ? -8388608 : s;
`else
    longint t = s & 64'hFFFFFF;
    return t >= 8388608 ? t - 16777216 : t;
`endif
  endfunction

  function automatic void chk(string n, longint got, longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, got, want);
    end
  endfunction

  // Behavioural model: y = floor((b.x - a.y) / 2^16), computed whole at accept time.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive = 0; busy = 0; cyc = 0; due = -1;
      sh = '{default: 0}; act = '{default: 0};
      x1 = 0; x2 = 0; y1 = 0; y2 = 0;
    end else begin
      cyc++;
      if (alive && !busy && sample_valid) begin
        act = sh;
        if (clear_state) begin x1 = 0; x2 = 0; y1 = 0; y2 = 0; end
        exp_y = reduce((act[0] * sample_in + act[1] * x1 + act[2] * x2 - act[3] * y1 - act[4] * y2) >>> 16);
        x2 = x1; x1 = sample_in; y2 = y1; y1 = exp_y;
        busy = 1; due = cyc + 6;
      end else begin
        if (clear_state) begin x1 = 0; x2 = 0; y1 = 0; y2 = 0; end
        if (busy && cyc == due) busy = 0;
      end
      if (coef_load) sh = '{b0, b1, b2, a1, a2};
      alive = 1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_ready", sample_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sample_out", sample_out, 0);
      last = 0;
    end else begin
      chk("sample_ready", sample_ready, alive && !busy);
      chk("out_valid", out_valid, cyc == due);
      if (cyc == due) begin
        last = exp_y;
        if (lit_i < lit_n) begin
          chk("model_vs_hand", exp_y, lit[lit_i]);
          chk("hand_out", sample_out, lit[lit_i]);
          lit_i++;
        end
      end
      chk("sample_out", sample_out, last);
    end
    if (done) begin
      chk("hand_count", lit_i, lit_n);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic tick(); @(posedge clk); #2; endtask
  task automatic want(longint v); lit[lit_n] = v; lit_n++; endtask
  task automatic clr(); clear_state = 1; tick(); clear_state = 0; endtask
  task automatic wait_ready(); for (int i = 0; i < 20 && !sample_ready; i++) tick(); endtask

  task automatic load(longint c0, longint c1, longint c2, longint c3, longint c4);
    b0 = W'(c0); b1 = W'(c1); b2 = W'(c2); a1 = W'(c3); a2 = W'(c4);
    coef_load = 1; tick(); coef_load = 0;
  endtask

  task automatic send(longint x, int hold = 0);
    wait_ready();
    sample_in = W'(x); sample_valid = 1; tick();
    repeat (hold) tick();
    sample_valid = 0;
    repeat (7 - hold) tick();
  endtask

  function automatic logic signed [W-1:0] rc();
    return $urandom_range(0, 3) == 0 ? W'($urandom) : W'(int'($urandom_range(0, 196608)) - 98304);
  endfunction

  initial begin
    repeat (2) tick();
    reset = 1; tick();
    load(65536, 0, 0, 0, 0); clr(); want(1000); send(1000);
    load(0, 65536, 0, 0, 0); clr(); want(0); send(5, 6); want(5); send(7); want(7); send(9);
    load(65536, 0, 0, -32768, 0); clr();
    want(1024); send(1024); want(512); send(0); want(256); send(0); want(128); send(0);
    load(131072, 0, 0, 0, 0); clr();
`ifdef SATURATE_EN
    want(8388607);
`else
    want(-777216);
`endif
    send(8000000);
    // coefficient swap while the pass-through computation is in MAC2
    load(65536, 0, 0, 0, 0); clr(); wait_ready(); want(100);
    sample_in = 100; sample_valid = 1; tick(); sample_valid = 0; tick(); tick();
    b0 = 32768; coef_load = 1; tick(); coef_load = 0; repeat (4) tick();
    want(50); send(100);
    // clear_state during MAC1 of a delay-filter computation
    load(0, 65536, 0, 0, 0); clr(); want(0); send(5);
    wait_ready(); want(5);
    sample_in = 7; sample_valid = 1; tick(); sample_valid = 0; tick();
    clear_state = 1; tick(); clear_state = 0; repeat (5) tick();
    want(0); send(9);
    // reset during MAC3 aborts the computation
    wait_ready();
    sample_in = 3; sample_valid = 1; tick(); sample_valid = 0; repeat (3) tick();
    reset = 0; repeat (3) tick(); reset = 1; tick();
    load(0, 65536, 0, 0, 0); want(0); send(4); want(4); send(6);
    for (int n = 0; n < 4000; n++) begin
      sample_valid = ($urandom_range(0, 2) == 0);
      sample_in = W'($urandom);
      coef_load = ($urandom_range(0, 29) == 0);
      if (coef_load) begin b0 = rc(); b1 = rc(); b2 = rc(); a1 = rc(); a2 = rc(); end
      clear_state = ($urandom_range(0, 39) == 0);
      reset = !($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1; sample_valid = 0; coef_load = 0; clear_state = 0;
    repeat (10) tick();
    done = 1;
  end
endmodule
